// File: rtl/fetch_stage_pkg.sv
// Shared defaults for the fetch front end and the default-width fetch entry.
package fetch_stage_pkg;

    localparam int          DEF_XLEN       = 32;
    localparam int          DEF_INST_WIDTH = 32;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam int          DEF_FQ_DEPTH   = 4;

    typedef struct packed {
        logic [DEF_INST_WIDTH-1:0] instr;
        logic [DEF_XLEN-1:0]       pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_fetch_queue.sv
// Synchronous FIFO with push/pop/clear; storage is not reset, only pointers and count.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: sequential PC generation, credit-limited imem requests,
// response buffering for decode, and flush/redirect with discard of in-flight fetches.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN       = DEF_XLEN,
    parameter int              INST_WIDTH = DEF_INST_WIDTH,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
    parameter int              FQ_DEPTH   = DEF_FQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [XLEN-1:0]       redirect_pc,
    input  logic                  stall,
    output logic                  imem_req_valid,
    output logic [XLEN-1:0]       imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic [INST_WIDTH-1:0] instr_out,
    output logic [XLEN-1:0]       pc_out,
    output logic                  valid_out
);

    localparam int            CW           = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_CREDIT = (CW + 1)'(FQ_DEPTH);

    typedef struct packed {
        logic [INST_WIDTH-1:0] instr;
        logic [XLEN-1:0]       pc;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   pc_count;
    logic            q_full, q_empty, pc_full, pc_empty;
    entry_t          q_din, q_dout;
    logic [XLEN-1:0] pc_head;
    logic            credit_ok, fire, q_push, q_pop;

    // Credit covers queued entries plus every in-flight request, dropped ones included,
    // so a returning response always finds a free queue slot.
    assign credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_CREDIT;
    assign imem_req_valid = !rst && !flush && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign fire           = imem_req_valid && imem_req_ready;

    assign q_push    = imem_resp_valid && (drop_cnt == '0) && !flush;
    assign q_pop     = valid_out && !stall && !flush;
    assign q_din     = '{instr: imem_resp_data, pc: pc_head};
    assign valid_out = !q_empty;
    assign instr_out = valid_out ? q_dout.instr : '0;
    assign pc_out    = valid_out ? q_dout.pc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (flush) begin
            // A response arriving in the flush cycle is itself discarded, so it is not
            // counted among the ones still to drop.
            fetch_pc    <= redirect_pc;
            outstanding <= outstanding - CW'(imem_resp_valid);
            drop_cnt    <= outstanding - CW'(imem_resp_valid);
        end else begin
            if (fire) fetch_pc <= fetch_pc + XLEN'(4);
            outstanding <= outstanding + CW'(fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    fetch_queue #(
        .WIDTH (INST_WIDTH + XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_din),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (count)
    );

    // Every response, kept or dropped, retires the oldest issued PC.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_pc_q (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .push  (fire),
        .pop   (imem_resp_valid),
        .din   (fetch_pc),
        .dout  (pc_head),
        .full  (pc_full),
        .empty (pc_empty),
        .count (pc_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && (outstanding == '0)));
            assert (({1'b0, count} + {1'b0, outstanding}) <= DEPTH_CREDIT);
            assert (!(q_push && q_full));
            assert (pc_count == outstanding);
            assert (!(imem_resp_valid && pc_empty));
            assert (!(fire && pc_full));
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with an in-order instruction memory model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, stall;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] instr_out, pc_out;
    logic        valid_out;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t         pend[$];
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nfires = 0;
    int lat = 1;
    bit rnd_ready = 0, rnd_lat = 0;
    bit c_rst = 1, c_flush = 0, c_stall = 1;
    logic [31:0] c_redir = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] p;
            p = start + 32'(4 * i);
            exp_q.push_back('{instr: mem_data(p), pc: p});
        end
    endtask

    // One clock cycle: apply controls at negedge, serve memory, record accepted requests.
    task automatic step();
        @(negedge clk);
        cyc++;
        rst         = c_rst;
        flush       = c_flush;
        redirect_pc = c_redir;
        stall       = c_stall;
        imem_req_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (c_rst) begin
            pend.delete();
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(pend[0].addr);
            void'(pend.pop_front());
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_req_addr,
                             due: cyc + (rnd_lat ? int'($urandom_range(1, 3)) : lat)});
            nfires++;
        end
        #2;
    endtask

    task automatic drain(input string name, input int budget, input bit rnd_stall);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            c_stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            step();
            n++;
        end
        c_stall = 1'b1;
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_flush(input logic [31:0] target);
        c_flush = 1'b1;
        c_redir = target;
        step();
        c_flush = 1'b0;
    endtask

    // Monitor: every cycle decode actually takes the head, compare against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (!rst && valid_out && !stall && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual_pc=%08h required=none", pc_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", pc_out, mon_e.pc);
                chk("out_instr", instr_out, mon_e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b1; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;

        // Reset, then a plain sequential stream with 1-cycle memory.
        c_rst = 1'b1; c_stall = 1'b1;
        step(); step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        expect_seq(32'h0, 8);
        c_rst = 1'b0; c_stall = 1'b0; lat = 1;
        step();
        chk("reset_valid_out", 32'(valid_out), 32'd0);
        chk("reset_instr_out", instr_out, 32'd0);
        chk("reset_pc_out", pc_out, 32'd0);
        chk("reset_req_valid", 32'(imem_req_valid), 32'd1);
        chk("reset_req_addr", imem_req_addr, 32'h0);
        step();
        chk("lat_n1_valid", 32'(valid_out), 32'd0);
        step();
        chk("lat_n2_valid", 32'(valid_out), 32'd1);
        chk("lat_n2_pc", pc_out, 32'h0);
        drain("seq_drain", 60, 1'b0);

        // Long stall: exactly FQ_DEPTH entries fetched, then requests stop.
        c_rst = 1'b1; step(); c_rst = 1'b0;
        nfires = 0;
        for (int i = 0; i < 20; i++) step();
        chk("stall_fires", 32'(nfires), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_head_pc", pc_out, 32'h0);
        expect_seq(32'h0, 5);
        drain("stall_drain", 60, 1'b0);

        // Random ready, random 1-3 cycle latency, random decode stalls.
        rnd_ready = 1'b1; rnd_lat = 1'b1;
        do_flush(32'h0000_0200);
        expect_seq(32'h0000_0200, 16);
        drain("rand_drain", 300, 1'b1);
        rnd_ready = 1'b0; rnd_lat = 1'b0;

        // Flush with 2 queued entries and 2 slow requests in flight.
        c_rst = 1'b1; step(); c_rst = 1'b0;
        nfires = 0; lat = 1;
        for (int i = 0; i < 20 && nfires < 4; i++) begin
            step();
            if (nfires >= 2) lat = 6;
        end
        step();
        chk("pre_flush_credit", 32'(imem_req_valid), 32'd0);
        chk("pre_flush_head", pc_out, 32'h0);
        lat = 1;
        do_flush(32'h0000_0100);
        step();
        chk("post_flush_valid", 32'(valid_out), 32'd0);
        expect_seq(32'h0000_0100, 4);
        drain("flush_drain", 60, 1'b0);

        // Flush coinciding with a response and a would-be decode pop.
        c_rst = 1'b1; step(); c_rst = 1'b0;
        nfires = 0; lat = 2;
        for (int i = 0; i < 20 && nfires < 3; i++) step();
        lat = 1;
        c_stall = 1'b0;
        do_flush(32'h0000_0300);
        chk("flush_cycle_valid", 32'(valid_out), 32'd1);
        c_stall = 1'b1;
        step();
        chk("flush2_valid", 32'(valid_out), 32'd0);
        expect_seq(32'h0000_0300, 3);
        drain("flush2_drain", 60, 1'b0);

        // PC wrap-around.
        do_flush(32'hFFFF_FFF8);
        expect_seq(32'hFFFF_FFF8, 3);
        drain("wrap_drain", 60, 1'b0);

        // Reset in the middle of a stream with entries still queued.
        for (int i = 0; i < 4; i++) step();
        c_rst = 1'b1; step(); c_rst = 1'b0;
        step();
        chk("midrst_valid", 32'(valid_out), 32'd0);
        chk("midrst_instr", instr_out, 32'd0);
        chk("midrst_pc", pc_out, 32'd0);
        chk("midrst_req_addr", imem_req_addr, 32'h0);
        expect_seq(32'h0, 3);
        drain("midrst_drain", 60, 1'b0);

        for (int i = 0; i < 5; i++) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
